gemm_c_drain: RTL and testbench
===============================

GEMM_C_DRAIN -- requirements
Module: gemm_c_drain

Interface
REQ-001 SHALL provide parameter OutDataWidth, default 32, width of one result element.
REQ-002 SHALL provide parameter AddrWidth, default 16, width of the SRAM C element address.
REQ-003 SHALL provide parameter SizeAddrWidth, default 8, width of matrix sizes and tile indices.
REQ-004 SHALL provide parameter RowPar, default 4, number of rows per result tile.
REQ-005 SHALL provide parameter ColPar, default 16, number of columns per tile, which is also the number of SRAM C write lanes.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports M_size_i and N_size_i, input, SizeAddrWidth each, the matrix C dimensions, held stable while busy_o=1.
REQ-009 SHALL have port tile_valid_i, input, 1, which asserts that a result tile is offered.
REQ-010 SHALL have port tile_ready_o, output, 1, which asserts that the block can accept a tile.
REQ-011 SHALL have port tile_data_i, input, RowPar x ColPar x OutDataWidth, signed, the tile results.
REQ-012 SHALL have ports tile_m_i and tile_n_i, input, SizeAddrWidth each, the tile row and column indices.
REQ-013 SHALL have port sram_c_addr_o, output, AddrWidth, the row base address; lane c writes to address sram_c_addr_o+c.
REQ-014 SHALL have port sram_c_wdata_o, output, ColPar x OutDataWidth, the row write data.
REQ-015 SHALL have port sram_c_be_o, output, ColPar, the per-lane write enable.
REQ-016 SHALL have port sram_c_we_o, output, 1, the row write strobe.
REQ-017 SHALL have port tile_done_o, output, 1, a one-cycle pulse when a tile has been fully drained.
REQ-018 SHALL have port busy_o, output, 1, high when any tile is held or being drained.

Function
REQ-019 SHALL capture tile_data_i, tile_m_i and tile_n_i on any cycle where tile_valid_i=1 and tile_ready_o=1; SHALL ignore all tile inputs otherwise.
REQ-020 SHALL implement FSM IDLE -> DRAIN on capture; DRAIN -> IDLE after the last valid row when no further tile is buffered; otherwise DRAIN -> DRAIN, continuing with the buffered tile.
REQ-021 SHALL treat row r as valid iff tile_m*RowPar + r < M_size_i, and lane c as valid iff tile_n*ColPar + c < N_size_i, computing both comparisons at full width without truncation.
REQ-022 SHALL issue one registered write per valid row, in ascending r order, one row per cycle, with the first write on the cycle after capture (latency 1), and SHALL NOT stall.
REQ-023 Each write SHALL set sram_c_we_o=1, sram_c_addr_o = (tile_m*RowPar + r)*N_size_i + tile_n*ColPar truncated to AddrWidth (wrap-around modulo 2^AddrWidth), sram_c_wdata_o = row r, and sram_c_be_o = lane-valid mask.
REQ-024 Invalid rows SHALL be skipped without consuming a cycle; rows are valid as a prefix, so the drain ends at the first invalid row.
REQ-025 SHALL pulse tile_done_o on the cycle of the last row write.
REQ-026 If row 0 of a tile is invalid (empty tile), SHALL issue zero writes and SHALL pulse tile_done_o one cycle after capture with sram_c_we_o=0.
REQ-027 Whenever sram_c_we_o=0, sram_c_be_o SHALL be 0; sram_c_addr_o and sram_c_wdata_o SHALL hold their last values.
REQ-028 busy_o SHALL equal (state==DRAIN) or (any tile buffered).

Reset
REQ-029 While rst_i=1 at a clock edge, the block SHALL enter IDLE and clear all tile buffers and the row counter.
REQ-030 Reset SHALL set sram_c_we_o=0, sram_c_be_o=0, sram_c_addr_o=0, sram_c_wdata_o=0, tile_done_o=0, busy_o=0, and tile_ready_o=0 while rst_i=1.
REQ-031 Reset asserted mid-drain SHALL abort the drain: no write after the reset edge, no tile_done_o pulse, and buffered tiles discarded.
REQ-032 SHALL assert tile_ready_o=1 on the first cycle after rst_i deasserts.

Configuration
REQ-033 Macro GEMM_C_DRAIN_DBUF_EN defined SHALL build a two-entry tile buffer: tile_ready_o=1 whenever a slot is free, including during DRAIN, so back-to-back tiles produce contiguous writes with no idle cycle.
REQ-034 Macro GEMM_C_DRAIN_DBUF_EN undefined SHALL build a single-entry buffer: tile_ready_o=1 only in IDLE; capture and last-row write SHALL NOT coincide.

Verification
REQ-035 Full tile: M=8, N=32, tile_m=1, tile_n=1, data[r][c]=16r+c -> 4 writes at addresses 144, 176, 208, 240, be=0xFFFF, tile_done_o on the 4th write.
REQ-036 Partial tile: M=6, N=20, tile_m=1, tile_n=1 -> 2 writes at addresses 96 and 116, be=0x000F, done on the 2nd write.
REQ-037 Empty tile: M=4, N=16, tile_m=1 -> zero writes, tile_done_o exactly one cycle after capture, busy_o returns to 0.
REQ-038 Back-to-back: two full tiles offered continuously -> without macro, tile_ready_o=0 for 4 cycles and there is a gap between tiles; with macro, the second tile is accepted during the drain and 8 consecutive write cycles occur.
REQ-039 Reset after the 2nd write of a full tile -> sram_c_we_o=0 from the next cycle, no tile_done_o pulse, tile_ready_o=1 one cycle after release.
REQ-040 Wrap: AddrWidth=8, M=N=32, tile_m=7, tile_n=1 -> row 31 address = (31*32+16) mod 256 = 240.

Source files
------------

// File: rtl/gemm_c_drain.sv
// Drains RowPar x ColPar result tiles into SRAM C one row per cycle; first write lands 1 cycle after capture.
// Never stalls once draining; GEMM_C_DRAIN_DBUF_EN adds a second tile slot so tiles can be accepted mid-drain.
module gemm_c_drain #(
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int RowPar        = 4,
  parameter int ColPar        = 16
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic [SizeAddrWidth-1:0]                              M_size_i,
  input  logic [SizeAddrWidth-1:0]                              N_size_i,
  input  logic                                                  tile_valid_i,
  output logic                                                  tile_ready_o,
  input  logic signed [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0] tile_data_i,
  input  logic [SizeAddrWidth-1:0]                              tile_m_i,
  input  logic [SizeAddrWidth-1:0]                              tile_n_i,
  output logic [AddrWidth-1:0]                                  sram_c_addr_o,
  output logic [ColPar-1:0][OutDataWidth-1:0]                   sram_c_wdata_o,
  output logic [ColPar-1:0]                                     sram_c_be_o,
  output logic                                                  sram_c_we_o,
  output logic                                                  tile_done_o,
  output logic                                                  busy_o
);

  localparam int RW  = (RowPar > 1) ? $clog2(RowPar) : 1;
  localparam int PW  = SizeAddrWidth + 34;
  localparam int AXW = 2 * SizeAddrWidth + AddrWidth + 34;
  localparam logic [RW:0] ROWS = (RW+1)'(RowPar);

  typedef logic [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0] tile_t;
  typedef logic [SizeAddrWidth-1:0] idx_t;
  typedef enum logic {IDLE, DRAIN} state_e;

  function automatic logic row_ok(input idx_t m, input logic [RW:0] r, input idx_t msize);
    return (PW'(m) * PW'(RowPar) + PW'(r)) < PW'(msize);
  endfunction

  function automatic logic [ColPar-1:0] lane_mask(input idx_t n, input idx_t nsize);
    logic [ColPar-1:0] mask;
    mask = '0;
    for (int c = 0; c < ColPar; c++) begin
      mask[c] = (PW'(n) * PW'(ColPar) + PW'(c)) < PW'(nsize);
    end
    return mask;
  endfunction

  function automatic logic [AddrWidth-1:0] row_addr(input idx_t m, input idx_t n,
                                                    input logic [RW:0] r, input idx_t nsize);
    logic [AXW-1:0] full;
    full = (AXW'(m) * AXW'(RowPar) + AXW'(r)) * AXW'(nsize) + AXW'(n) * AXW'(ColPar);
    return AddrWidth'(full);
  endfunction

  state_e         state_q, state_d;
  tile_t          cur_dat;
  idx_t           cur_m, cur_n;
  logic [RW-1:0]  row_q;

  logic           cap, start, step, load_pend, clr_pend;
  tile_t          src_dat;
  idx_t           src_m, src_n;
  logic [RW:0]    sel_r, nxt_r;
  logic           sel_ok, sel_last;

`ifdef GEMM_C_DRAIN_DBUF_EN
  logic           pend_vld_q;
  tile_t          pend_dat;
  idx_t           pend_m, pend_n;

  assign tile_ready_o = !rst_i && !pend_vld_q;
  assign busy_o       = !rst_i && ((state_q == DRAIN) || pend_vld_q);
`else
  assign tile_ready_o = !rst_i && (state_q == IDLE);
  assign busy_o       = !rst_i && (state_q == DRAIN);
`endif

  assign cap = tile_valid_i && tile_ready_o;

  // tile_done_o doubles as "the row on the outputs is the tile's last one"
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    step      = 1'b0;
    load_pend = 1'b0;
    clr_pend  = 1'b0;
    src_dat   = cur_dat;
    src_m     = cur_m;
    src_n     = cur_n;
    sel_r     = {1'b0, row_q} + {{RW{1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        if (cap) begin
          start   = 1'b1;
          src_dat = tile_data_i;
          src_m   = tile_m_i;
          src_n   = tile_n_i;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!tile_done_o) begin
          step = 1'b1;
`ifdef GEMM_C_DRAIN_DBUF_EN
          load_pend = cap;
`endif
        end else begin
`ifdef GEMM_C_DRAIN_DBUF_EN
          if (pend_vld_q) begin
            start    = 1'b1;
            clr_pend = 1'b1;
            src_dat  = pend_dat;
            src_m    = pend_m;
            src_n    = pend_n;
          end else if (cap) begin
            start   = 1'b1;
            src_dat = tile_data_i;
            src_m   = tile_m_i;
            src_n   = tile_n_i;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) sel_r = '0;
    nxt_r    = sel_r + {{RW{1'b0}}, 1'b1};
    sel_ok   = row_ok(src_m, sel_r, M_size_i);
    sel_last = !((nxt_r < ROWS) && row_ok(src_m, nxt_r, M_size_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cur_dat        <= '0;
      cur_m          <= '0;
      cur_n          <= '0;
      row_q          <= '0;
      sram_c_we_o    <= 1'b0;
      sram_c_be_o    <= '0;
      sram_c_addr_o  <= '0;
      sram_c_wdata_o <= '0;
      tile_done_o    <= 1'b0;
`ifdef GEMM_C_DRAIN_DBUF_EN
      pend_vld_q     <= 1'b0;
      pend_dat       <= '0;
      pend_m         <= '0;
      pend_n         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sram_c_we_o <= 1'b0;
      sram_c_be_o <= '0;
      tile_done_o <= 1'b0;
      if (start) begin
        cur_dat <= src_dat;
        cur_m   <= src_m;
        cur_n   <= src_n;
        row_q   <= '0;
      end else if (step) begin
        row_q <= row_q + 1'b1;
      end
      if (start || step) begin
        tile_done_o <= sel_last || !sel_ok;
        if (sel_ok) begin
          sram_c_we_o    <= 1'b1;
          sram_c_be_o    <= lane_mask(src_n, N_size_i);
          sram_c_addr_o  <= row_addr(src_m, src_n, sel_r, N_size_i);
          sram_c_wdata_o <= src_dat[sel_r[RW-1:0]];
        end
      end
`ifdef GEMM_C_DRAIN_DBUF_EN
      if (load_pend) begin
        pend_vld_q <= 1'b1;
        pend_dat   <= tile_data_i;
        pend_m     <= tile_m_i;
        pend_n     <= tile_n_i;
      end else if (clr_pend) begin
        pend_vld_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gemm_c_drain.sv
// Directed bench for gemm_c_drain: tile vector table plus back-to-back and mid-drain reset sequences.
module tb_gemm_c_drain;
  localparam int ODW = 32;
  localparam int RP  = 4;
  localparam int CP  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                               rst;
  logic [7:0]                         m_size, n_size, tile_m, tile_n;
  logic                               tile_valid, tile_ready;
  logic signed [RP-1:0][CP-1:0][ODW-1:0] tile_data;
  logic [15:0]                        addr;
  logic [CP-1:0][ODW-1:0]             wdata;
  logic [CP-1:0]                      be;
  logic                               we, done, busy;
  logic                               w_ready, w_we, w_done, w_busy;
  logic [7:0]                         w_addr;
  logic [CP-1:0][ODW-1:0]             w_wdata;
  logic [CP-1:0]                      w_be;

  gemm_c_drain dut (
    .clk_i(clk), .rst_i(rst), .M_size_i(m_size), .N_size_i(n_size),
    .tile_valid_i(tile_valid), .tile_ready_o(tile_ready), .tile_data_i(tile_data),
    .tile_m_i(tile_m), .tile_n_i(tile_n), .sram_c_addr_o(addr), .sram_c_wdata_o(wdata),
    .sram_c_be_o(be), .sram_c_we_o(we), .tile_done_o(done), .busy_o(busy)
  );

  gemm_c_drain #(.AddrWidth(8)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .M_size_i(m_size), .N_size_i(n_size),
    .tile_valid_i(tile_valid), .tile_ready_o(w_ready), .tile_data_i(tile_data),
    .tile_m_i(tile_m), .tile_n_i(tile_n), .sram_c_addr_o(w_addr), .sram_c_wdata_o(w_wdata),
    .sram_c_be_o(w_be), .sram_c_we_o(w_we), .tile_done_o(w_done), .busy_o(w_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_tile(input int base);
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++)
        tile_data[r][c] = base + 16 * r + c;
  endtask

  typedef struct {
    int m_size, n_size, tm, tn;
    int rows, addr0, waddr0, stride, be, base;
  } vec_t;
  vec_t vecs[8];

  task automatic run_vec(input int id, input vec_t v);
    logic [15:0]            ea;
    logic [7:0]             ew;
    logic [CP-1:0][ODW-1:0] er;
    @(negedge clk);
    m_size = 8'(v.m_size); n_size = 8'(v.n_size);
    tile_m = 8'(v.tm);     tile_n = 8'(v.tn);
    fill_tile(v.base);
    tile_valid = 1'b1;
    chk($sformatf("v%0d_ready", id), tile_ready, 1);
    @(negedge clk);
    tile_valid = 1'b0;
    for (int k = 0; k < v.rows; k++) begin
      if (k > 0) @(negedge clk);
      ea = 16'(v.addr0 + k * v.stride);
      ew = 8'(v.waddr0 + k * v.stride);
      for (int c = 0; c < CP; c++) er[c] = v.base + 16 * k + c;
      chk($sformatf("v%0d_r%0d_we", id, k), we, 1);
      chk($sformatf("v%0d_r%0d_addr", id, k), addr, ea);
      chk($sformatf("v%0d_r%0d_waddr", id, k), w_addr, ew);
      chk($sformatf("v%0d_r%0d_be", id, k), be, v.be);
      chk($sformatf("v%0d_r%0d_wdata", id, k), wdata, er);
      chk($sformatf("v%0d_r%0d_done", id, k), done, (k == v.rows - 1) ? 1 : 0);
    end
    if (v.rows == 0) begin
      chk($sformatf("v%0d_empty_we", id), we, 0);
      chk($sformatf("v%0d_empty_done", id), done, 1);
      chk($sformatf("v%0d_empty_busy", id), busy, 1);
    end
    @(negedge clk);
    chk($sformatf("v%0d_post_we", id), we, 0);
    chk($sformatf("v%0d_post_be", id), be, 0);
    chk($sformatf("v%0d_post_done", id), done, 0);
    chk($sformatf("v%0d_post_busy", id), busy, 0);
    if (v.rows > 0) chk($sformatf("v%0d_addr_hold", id), addr, ea);
  endtask

  task automatic run_b2b();
    int wr_cyc[$];
    int wr_adr[$];
    int done_cyc[$];
    int exp_cyc[8];
    int exp_done[2];
    int exp_adr[8];
    int idx, rdy_low, b_cap;
    logic cap_pend;
`ifdef GEMM_C_DRAIN_DBUF_EN
    exp_cyc  = '{1, 2, 3, 4, 5, 6, 7, 8};
    exp_done = '{4, 8};
    rdy_low  = 0;
`else
    exp_cyc  = '{1, 2, 3, 4, 6, 7, 8, 9};
    exp_done = '{4, 9};
`endif
    exp_adr = '{0, 32, 64, 96, 128, 160, 192, 224};
    idx = 0; rdy_low = 0; b_cap = -1; cap_pend = 1'b0;
    @(negedge clk);
    m_size = 8; n_size = 32; tile_m = 0; tile_n = 0;
    fill_tile('h1000);
    tile_valid = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (t > 0) @(negedge clk);
      if (cap_pend) begin
        idx++;
        if (idx == 1) begin tile_m = 1; fill_tile('h2000); end
        else tile_valid = 1'b0;
      end
      if (we) begin wr_cyc.push_back(t); wr_adr.push_back(int'(addr)); end
      if (done) done_cyc.push_back(t);
      if (tile_valid && idx == 1 && !tile_ready) rdy_low++;
      cap_pend = tile_valid && tile_ready;
      if (cap_pend && idx == 1) b_cap = t;
    end
    chk("b2b_nwrites", wr_cyc.size(), 8);
    for (int i = 0; i < 8 && i < wr_cyc.size(); i++) begin
      chk($sformatf("b2b_w%0d_cycle", i), wr_cyc[i], exp_cyc[i]);
      chk($sformatf("b2b_w%0d_addr", i), wr_adr[i], exp_adr[i]);
    end
    chk("b2b_ndone", done_cyc.size(), 2);
    for (int i = 0; i < 2 && i < done_cyc.size(); i++)
      chk($sformatf("b2b_done%0d_cycle", i), done_cyc[i], exp_done[i]);
`ifdef GEMM_C_DRAIN_DBUF_EN
    chk("b2b_ready_low", rdy_low, 0);
    chk("b2b_b_capture", b_cap, 1);
`else
    chk("b2b_ready_low", rdy_low, 4);
    chk("b2b_b_capture", b_cap, 5);
`endif
    chk("b2b_idle_busy", busy, 0);
  endtask

  task automatic run_reset_mid();
    int seen;
    @(negedge clk);
    m_size = 8; n_size = 32; tile_m = 1; tile_n = 1;
    fill_tile('h3000);
    tile_valid = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    chk("rstm_w1_we", we, 1);
    @(negedge clk);
    chk("rstm_w2_we", we, 1);
    chk("rstm_w2_addr", addr, 176);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_we", we, 0);
    chk("rstm_done", done, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_ready_in_rst", tile_ready, 0);
    chk("rstm_be", be, 0);
    chk("rstm_addr", addr, 0);
    chk("rstm_wdata", wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_ready_after", tile_ready, 1);
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge clk);
      if (we || done || busy) seen++;
    end
    chk("rstm_no_activity", seen, 0);
  endtask

  initial begin
    vecs[0] = '{8,   32,  1,  1,  4, 144,   144, 32,  'hFFFF, 'h100};
    vecs[1] = '{6,   20,  1,  1,  2, 96,    96,  20,  'h000F, 'h200};
    vecs[2] = '{4,   16,  1,  0,  0, 0,     0,   16,  'h0000, 'h300};
    vecs[3] = '{3,   16,  0,  0,  3, 0,     0,   16,  'hFFFF, 'h400};
    vecs[4] = '{255, 255, 63, 15, 3, 64500, 244, 255, 'h7FFF, 'h500};
    vecs[5] = '{255, 255, 64, 0,  0, 0,     0,   255, 'h0000, 'h600};
    vecs[6] = '{5,   17,  1,  1,  1, 84,    84,  17,  'h0001, 'h700};
    vecs[7] = '{32,  32,  7,  1,  4, 912,   144, 32,  'hFFFF, 'h800};

    rst = 1'b1; tile_valid = 1'b0;
    m_size = 0; n_size = 0; tile_m = 0; tile_n = 0;
    fill_tile(0);
    repeat (2) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_be", be, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tile_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", tile_ready, 1);
    chk("rel_busy", busy, 0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    run_b2b();
    run_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
